// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
package adder_pkg;

    // Operation selected by the in_sub port.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Per-slot control travelling with each beat: slot occupancy, carry out
    // of the chunks completed so far, and the overflow of the latest chunk.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } slot_ctrl_t;

    // Width of one carry-chain chunk handled by a single pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // True when the width/stage combination splits into equal chunks.
    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit adder slice: sum, carry out, and carry into its MSB.
module adder_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    logic [CW:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    assign sum     = total_s[CW-1:0];
    assign cout    = total_s[CW];
    // The MSB sum bit is a ^ b ^ carry-in, so the carry into it falls out.
    assign c_msb   = a[CW-1] ^ b[CW-1] ^ total_s[CW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract unit. The carry chain is cut into
// STAGES chunks; each stage resolves one chunk and hands its carry onward.
module pipelined_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Subtraction is A + ~B + ~borrow; the operands are conditioned once at
    // entry so every stage is a plain adder.
    op_e             op_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;
    logic             stall_s;

    // Stage registers: control, completed low sum chunks, and the not-yet
    // consumed operand bits shifted so the next chunk always sits at bit 0.
    slot_ctrl_t       ctrl_r  [STAGES];
    logic [WIDTH-1:0] sum_r   [STAGES];
    logic [WIDTH-1:0] rem_a_r [STAGES];
    logic [WIDTH-1:0] rem_b_r [STAGES];

    // Per-stage chunk adder connections.
    logic [CW-1:0] ch_a_s    [STAGES];
    logic [CW-1:0] ch_b_s    [STAGES];
    logic          ch_cin_s  [STAGES];
    logic [CW-1:0] ch_sum_s  [STAGES];
    logic          ch_cout_s [STAGES];
    logic          ch_cmsb_s [STAGES];

    assign op_s      = op_e'(in_sub);
    assign b_eff_s   = (op_s == OP_SUB) ? ~in_b : in_b;
    assign cin_eff_s = (op_s == OP_SUB) ? ~in_cin : in_cin;

    // Backpressure only ever comes from an unconsumed result at the output.
    assign stall_s   = ctrl_r[STAGES-1].valid & ~out_ready;
    assign in_ready  = ~stall_s;

    assign out_valid = ctrl_r[STAGES-1].valid;
    assign out_sum   = sum_r[STAGES-1];
    assign out_cout  = ctrl_r[STAGES-1].carry;
    assign out_ovf   = ctrl_r[STAGES-1].ovf;

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        if (k == 0) begin : g_first
            assign ch_a_s[k]   = in_a[CW-1:0];
            assign ch_b_s[k]   = b_eff_s[CW-1:0];
            assign ch_cin_s[k] = cin_eff_s;
        end else begin : g_next
            assign ch_a_s[k]   = rem_a_r[k-1][CW-1:0];
            assign ch_b_s[k]   = rem_b_r[k-1][CW-1:0];
            assign ch_cin_s[k] = ctrl_r[k-1].carry;
        end

        adder_chunk #(
            .CW (CW)
        ) u_chunk (
            .a     (ch_a_s[k]),
            .b     (ch_b_s[k]),
            .cin   (ch_cin_s[k]),
            .sum   (ch_sum_s[k]),
            .cout  (ch_cout_s[k]),
            .c_msb (ch_cmsb_s[k])
        );
    end

    // Pipeline advance: reset clears all slots, a stall freezes every stage,
    // otherwise each slot (valid or bubble) moves down one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_r[k]  <= '0;
                sum_r[k]   <= '0;
                rem_a_r[k] <= '0;
                rem_b_r[k] <= '0;
            end
        end else if (!stall_s) begin
            ctrl_r[0].valid <= in_valid;
            ctrl_r[0].carry <= ch_cout_s[0];
            ctrl_r[0].ovf   <= ch_cout_s[0] ^ ch_cmsb_s[0];
            sum_r[0]        <= WIDTH'(ch_sum_s[0]);
            rem_a_r[0]      <= in_a >> CW;
            rem_b_r[0]      <= b_eff_s >> CW;
            for (int k = 1; k < STAGES; k++) begin
                ctrl_r[k].valid <= ctrl_r[k-1].valid;
                ctrl_r[k].carry <= ch_cout_s[k];
                ctrl_r[k].ovf   <= ch_cout_s[k] ^ ch_cmsb_s[k];
                sum_r[k]        <= sum_r[k-1] | (WIDTH'(ch_sum_s[k]) << (k * CW));
                rem_a_r[k]      <= rem_a_r[k-1] >> CW;
                rem_b_r[k]      <= rem_b_r[k-1] >> CW;
            end
        end
    end

endmodule
